sensor_conditioner: RTL and testbench
=====================================

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 16, consecutive stable cycles required before a debounced output changes (range 2..255).
REQ-002 Parameter ERR_HOLD, default 8, consecutive cycles of a level-combination condition required to enter or leave fault (range 2..255).
REQ-003 clock  input  1  system clock; the only clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 raw_h, raw_m, raw_l  input  1 each  raw high/mid/low tank level sensors; 1 = sensor covered by water; asynchronous to clock.
REQ-006 raw_bs, raw_vs, raw_ve  input  1 each  raw sprinkler-select, drip-select and drain-valve-end switches; asynchronous.
REQ-007 H, M, L  output  1 each  debounced level sensors, registered.
REQ-008 Bs, Vs, Ve  output  1 each  single-cycle pulses on the debounced rising edge of the matching switch, registered.
REQ-009 E  output  1  sensor-fault flag, registered, glitch-free; drives the controller's asynchronous error input.
REQ-010 level  output  2  count of covered sensors (0..3), registered; 0 while E=1.

Function
REQ-011 Each raw input passes through a 2-flop synchroniser before any other logic.
REQ-012 Each channel has its own debounce counter; it clears whenever the synchronised value equals the current debounced value, and otherwise increments.
REQ-013 A debounced value toggles on the edge at which its counter reaches DB_CYCLES; a clean raw step is visible at the output exactly DB_CYCLES+2 cycles after first sampling.
REQ-014 A raw pulse shorter than DB_CYCLES cycles after synchronisation produces no output change.
REQ-015 Bs, Vs, Ve are high for exactly one cycle per debounced 0->1 transition; a held switch produces no repeat pulses.
REQ-016 If Bs and Vs would pulse in the same cycle, only Bs pulses; the Vs pulse is discarded.
REQ-017 Bs and Vs are suppressed (held 0) while E=1; Ve is not suppressed.
REQ-018 The debounced {H,M,L} combination is valid only for 000, 001, 011 and 111; all other combinations are invalid.
REQ-019 The fault FSM has states OK, SUSPECT, FAULT and RECOVER, plus a hold counter.
REQ-020 OK: an invalid combination moves the FSM to SUSPECT with count=1.
REQ-021 SUSPECT: a valid combination returns the FSM to OK; an invalid one increments the count; on the ERR_HOLD-th consecutive invalid sample the FSM moves to FAULT.
REQ-022 FAULT: a valid combination moves the FSM to RECOVER with count=1.
REQ-023 RECOVER: an invalid combination returns the FSM to FAULT; on the ERR_HOLD-th consecutive valid sample the FSM moves to OK.
REQ-024 E=1 exactly while the FSM is in FAULT or RECOVER; E is decoded from registered state only.
REQ-025 level = H+M+L when E=0 and 0 when E=1, updated on the same edge as H/M/L and E.

Reset
REQ-026 reset_n=0 asynchronously clears synchronisers, debounce counters, H, M, L, Bs, Vs, Ve, E, level (all outputs 0), and returns the FSM to OK with count 0.
REQ-027 Reset asserted mid-debounce or mid-SUSPECT/RECOVER discards all partial counts.
REQ-028 After reset release, inputs already high reach their outputs DB_CYCLES+2 cycles later; no Bs/Vs/Ve pulse is generated unless a 0->1 debounced edge occurs.

Configuration
REQ-029 The macro SENSOR_ERR_STICKY_EN controls fault recovery.
REQ-030 When SENSOR_ERR_STICKY_EN is defined, FAULT has no exit: E remains 1 until reset_n=0 and RECOVER is unreachable.
REQ-031 When SENSOR_ERR_STICKY_EN is undefined, recovery follows REQ-022 and REQ-023.

Verification
REQ-032 (DB_CYCLES=4) raw_l 0->1 held -> L rises exactly 6 cycles later; level=1.
REQ-033 (DB_CYCLES=4) raw_h 3-cycle glitch -> H stays 0, no E.
REQ-034 raw_bs and raw_vs rise in the same cycle, held 20 cycles -> exactly one Bs pulse, zero Vs pulses.
REQ-035 (ERR_HOLD=8) debounced {H,M,L}=100 held -> E rises on the 8th invalid sample; Bs is blocked; level=0. Restore 111 -> E falls after 8 valid cycles. Repeat with 7 invalid samples -> E never rises.
REQ-036 (SENSOR_ERR_STICKY_EN defined) fault entered, then valid 111 held 50 cycles -> E stays 1; reset_n pulse -> E=0 and all outputs 0.

Source files
------------

// File: rtl/sensor_conditioner_if.sv
// Raw sensor/switch inputs and conditioned outputs of sensor_conditioner.
// dbg_state mirrors the fault FSM state for observation only.
interface sensor_conditioner_if;
   logic       raw_h, raw_m, raw_l;
   logic       raw_bs, raw_vs, raw_ve;
   logic       H, M, L;
   logic       Bs, Vs, Ve;
   logic       E;
   logic [1:0] level;
   logic [1:0] dbg_state;

   modport master (
      output raw_h, raw_m, raw_l, raw_bs, raw_vs, raw_ve,
      input  H, M, L, Bs, Vs, Ve, E, level, dbg_state
   );

   modport slave (
      input  raw_h, raw_m, raw_l, raw_bs, raw_vs, raw_ve,
      output H, M, L, Bs, Vs, Ve, E, level, dbg_state
   );
endinterface

// File: rtl/sensor_conditioner.sv
// Synchronise, debounce and sanity-check tank level sensors and operator switches.
// Build option SENSOR_ERR_STICKY_EN: when defined, a sensor fault is held until reset.
module sensor_conditioner #(
   parameter int DB_CYCLES = 16,
   parameter int ERR_HOLD  = 8
) (
   input logic                 clock,
   input logic                 reset_n,
   sensor_conditioner_if.slave bus
);

   localparam int NCH   = 6;
   localparam int CH_L  = 0;
   localparam int CH_M  = 1;
   localparam int CH_H  = 2;
   localparam int CH_BS = 3;
   localparam int CH_VS = 4;
   localparam int CH_VE = 5;

   localparam logic [7:0] DB_LAST   = 8'(DB_CYCLES - 1);
   localparam logic [7:0] HOLD_LAST = 8'(ERR_HOLD - 1);

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_SUSPECT = 2'd1,
      ST_FAULT   = 2'd2,
      ST_RECOVER = 2'd3
   } fault_state_t;

   logic [NCH-1:0] raw;
   logic [NCH-1:0] sync_a;
   logic [NCH-1:0] sync_b;
   logic [NCH-1:0] deb;
   logic [NCH-1:0] toggle;
   logic [NCH-1:0] deb_next;
   logic [7:0]     db_cnt [NCH];

   logic           rise_bs, rise_vs, rise_ve;
   logic           bs_pulse, vs_pulse, ve_pulse;
   logic           combo_ok;
   fault_state_t   state;
   logic [7:0]     hold;
   logic           err;
   logic [1:0]     level_q;

   function automatic logic [1:0] count_hml(input logic [2:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

   assign raw = {bus.raw_ve, bus.raw_vs, bus.raw_bs, bus.raw_h, bus.raw_m, bus.raw_l};

   // A channel flips on the edge where its disagreement run reaches DB_CYCLES.
   always_comb begin
      toggle = '0;
      for (int i = 0; i < NCH; i++) begin
         toggle[i] = (sync_b[i] != deb[i]) && (db_cnt[i] == DB_LAST);
      end
   end

   assign deb_next = deb ^ toggle;
   assign rise_bs  = toggle[CH_BS] & ~deb[CH_BS];
   assign rise_vs  = toggle[CH_VS] & ~deb[CH_VS];
   assign rise_ve  = toggle[CH_VE] & ~deb[CH_VE];

   // Water fills from the bottom, so only 000, 001, 011, 111 are physical.
   assign combo_ok = {deb[CH_H], deb[CH_M], deb[CH_L]} inside {3'b000, 3'b001, 3'b011, 3'b111};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_a <= '0;
         sync_b <= '0;
         deb    <= '0;
         for (int i = 0; i < NCH; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
         deb    <= deb_next;
         for (int i = 0; i < NCH; i++) begin
            if ((sync_b[i] == deb[i]) || toggle[i]) begin
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 8'd1;
            end
         end
      end
   end

   // Bs wins a tie with Vs; both are muted during a fault, Ve never is.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bs_pulse <= 1'b0;
         vs_pulse <= 1'b0;
         ve_pulse <= 1'b0;
      end else begin
         bs_pulse <= rise_bs & ~err;
         vs_pulse <= rise_vs & ~rise_bs & ~err;
         ve_pulse <= rise_ve;
      end
   end

   // Fault FSM; level follows the new H/M/L and is forced to 0 whenever E is set.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_OK;
         hold    <= '0;
         err     <= 1'b0;
         level_q <= '0;
      end else begin
         level_q <= err ? 2'd0 : count_hml({deb_next[CH_H], deb_next[CH_M], deb_next[CH_L]});
         case (state)
            ST_OK: begin
               if (!combo_ok) begin
                  state <= ST_SUSPECT;
                  hold  <= 8'd1;
               end
            end
            ST_SUSPECT: begin
               if (combo_ok) begin
                  state <= ST_OK;
                  hold  <= '0;
               end else if (hold == HOLD_LAST) begin
                  state   <= ST_FAULT;
                  hold    <= '0;
                  err     <= 1'b1;
                  level_q <= 2'd0;
               end else begin
                  hold <= hold + 8'd1;
               end
            end
            ST_FAULT: begin
`ifdef SENSOR_ERR_STICKY_EN
               state <= ST_FAULT;
`else
               if (combo_ok) begin
                  state <= ST_RECOVER;
                  hold  <= 8'd1;
               end
`endif
            end
            ST_RECOVER: begin
               if (!combo_ok) begin
                  state <= ST_FAULT;
                  hold  <= '0;
               end else if (hold == HOLD_LAST) begin
                  state   <= ST_OK;
                  hold    <= '0;
                  err     <= 1'b0;
                  level_q <= count_hml({deb_next[CH_H], deb_next[CH_M], deb_next[CH_L]});
               end else begin
                  hold <= hold + 8'd1;
               end
            end
            default: begin
               state <= ST_OK;
               hold  <= '0;
               err   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.H         = deb[CH_H];
   assign bus.M         = deb[CH_M];
   assign bus.L         = deb[CH_L];
   assign bus.Bs        = bs_pulse;
   assign bus.Vs        = vs_pulse;
   assign bus.Ve        = ve_pulse;
   assign bus.E         = err;
   assign bus.level     = level_q;
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: run-length reference model feeding an expected
// queue, a negedge monitor comparing every cycle, plus directed timing checks.
module tb_sensor_conditioner;

   localparam int DB = 4;
   localparam int EH = 8;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   logic [5:0] raw_v = '0;   // {ve, vs, bs, h, m, l}

   sensor_conditioner_if bus ();

   assign bus.raw_l  = raw_v[0];
   assign bus.raw_m  = raw_v[1];
   assign bus.raw_h  = raw_v[2];
   assign bus.raw_bs = raw_v[3];
   assign bus.raw_vs = raw_v[4];
   assign bus.raw_ve = raw_v[5];

   sensor_conditioner #(.DB_CYCLES(DB), .ERR_HOLD(EH)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int compared    = 0;
   int mismatched  = 0;
   int fail_prints = 0;
   int bs_seen     = 0;
   int vs_seen     = 0;
   int e_seen      = 0;
   int h_seen      = 0;

   logic [8:0] exp_q[$];

   // ---------------- reference model ----------------
   logic [5:0] hist[$];      // sampled raw values, oldest first, length DB+2
   logic [5:0] m_deb;
   logic       m_e;
   int         inv_run;
   int         val_run;

   logic [5:0] old_deb, flips, rises;
   logic       e_old, e_new, combo_valid, all_diff;
   logic       x_bs, x_vs, x_ve;
   int         lvl;

   task automatic model_reset();
      hist.delete();
      for (int j = 0; j < DB + 2; j++) hist.push_back(6'b0);
      m_deb   = '0;
      m_e     = 1'b0;
      inv_run = 0;
      val_run = 0;
   endtask

   always @(posedge clock) begin
      if (!reset_n) begin
         model_reset();
         exp_q.push_back(9'b0);
      end else begin
         old_deb = m_deb;
         e_old   = m_e;
         hist.push_back(raw_v);
         void'(hist.pop_front());
         // A channel flips when the DB samples seen through the 2-flop delay all disagree with it.
         flips = '0;
         for (int c = 0; c < 6; c++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++) begin
               if (hist[j][c] == old_deb[c]) all_diff = 1'b0;
            end
            flips[c] = all_diff;
         end
         combo_valid = old_deb[2:0] inside {3'b000, 3'b001, 3'b011, 3'b111};
         if (combo_valid) begin
            val_run++;
            inv_run = 0;
         end else begin
            inv_run++;
            val_run = 0;
         end
         e_new = e_old;
         if (!e_old && inv_run >= EH) e_new = 1'b1;
`ifndef SENSOR_ERR_STICKY_EN
         if (e_old && val_run >= EH) e_new = 1'b0;
`endif
         m_deb = old_deb ^ flips;
         rises = flips & ~old_deb;
         x_bs  = rises[3] & ~e_old;
         x_vs  = rises[4] & ~rises[3] & ~e_old;
         x_ve  = rises[5];
         lvl   = e_new ? 0 : (int'(m_deb[0]) + int'(m_deb[1]) + int'(m_deb[2]));
         m_e   = e_new;
         exp_q.push_back({m_deb[2], m_deb[1], m_deb[0], x_bs, x_vs, x_ve, e_new, 2'(lvl)});
      end
   end

   // ---------------- monitor ----------------
   logic [8:0] got_v, want_v;

   always @(negedge clock) begin
      got_v = {bus.H, bus.M, bus.L, bus.Bs, bus.Vs, bus.Ve, bus.E, bus.level};
      bs_seen += int'(bus.Bs);
      vs_seen += int'(bus.Vs);
      e_seen  += int'(bus.E);
      h_seen  += int'(bus.H);
      if (exp_q.size() > 0) begin
         want_v = exp_q.pop_front();
         compared++;
         if (got_v !== want_v) begin
            mismatched++;
            if (fail_prints < 30) begin
               fail_prints++;
               $display("FAIL outputs {H,M,L,Bs,Vs,Ve,E,level} at t=%0t: got %b, required %b",
                        $time, got_v, want_v);
            end
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clock);
      #1;
   endtask

   task automatic check(input string name, input int actual, input int required);
      compared++;
      if (actual != required) begin
         mismatched++;
         $display("FAIL %s at t=%0t: got %0d, required %0d", name, $time, actual, required);
      end
   endtask

   task automatic pulse_reset(input int n);
      reset_n = 1'b0;
      tick(n);
      reset_n = 1'b1;
   endtask

   function automatic int outs_packed();
      return int'({bus.H, bus.M, bus.L, bus.Bs, bus.Vs, bus.Ve, bus.E, bus.level});
   endfunction

   int sticky_e;
   int seg_len;
   logic [2:0] valid_combo;

   initial begin
`ifdef SENSOR_ERR_STICKY_EN
      sticky_e = 1;
`else
      sticky_e = 0;
`endif
      raw_v   = '0;
      reset_n = 1'b0;
      tick(2);
      check("reset_outputs", outs_packed(), 0);
      reset_n = 1'b1;
      tick(2);

      // raw_l step: L appears on the (DB+2)-th edge
      raw_v[0] = 1'b1;
      tick(DB + 1);
      check("l_before_latency", int'(bus.L), 0);
      tick(1);
      check("l_at_latency", int'(bus.L), 1);
      check("level_one", int'(bus.level), 1);
      tick(6);

      // short glitch on raw_h
      h_seen = 0;
      e_seen = 0;
      raw_v[2] = 1'b1;
      tick(DB - 1);
      raw_v[2] = 1'b0;
      tick(12);
      check("glitch_h_seen", h_seen, 0);
      check("glitch_e_seen", e_seen, 0);

      // Bs and Vs rising together
      bs_seen = 0;
      vs_seen = 0;
      raw_v[3] = 1'b1;
      raw_v[4] = 1'b1;
      tick(20);
      raw_v[3] = 1'b0;
      raw_v[4] = 1'b0;
      tick(8);
      check("tie_bs_pulses", bs_seen, 1);
      check("tie_vs_pulses", vs_seen, 0);

      // invalid 100 held: E on the EH-th invalid sample
      raw_v[2:0] = 3'b100;
      tick(DB + 1 + EH);
      check("e_before_hold", int'(bus.E), 0);
      tick(1);
      check("e_after_hold", int'(bus.E), 1);
      check("level_in_fault", int'(bus.level), 0);
      bs_seen = 0;
      raw_v[3] = 1'b1;
      tick(10);
      raw_v[3] = 1'b0;
      check("bs_blocked", bs_seen, 0);

      // restore 111: E clears after EH valid samples unless sticky
      raw_v[2:0] = 3'b111;
      tick(DB + 1 + EH);
      check("e_recover_before", int'(bus.E), 1);
      tick(1);
      check("e_recover_after", int'(bus.E), sticky_e);
      tick(50 - (DB + 2 + EH));
      check("e_after_50_valid", int'(bus.E), sticky_e);
      reset_n = 1'b0;
      tick(1);
      check("reset_mid_run", outs_packed(), 0);
      reset_n = 1'b1;
      tick(DB + 6);
      check("h_after_reset_release", int'(bus.H), 1);

      // EH-1 invalid samples: no fault
      raw_v[2:0] = 3'b000;
      tick(DB + 6);
      e_seen = 0;
      raw_v[2] = 1'b1;
      tick(EH - 1);
      raw_v[2] = 1'b0;
      tick(20);
      check("seven_invalid_no_e", e_seen, 0);

      // EH invalid samples: fault
      raw_v[2] = 1'b1;
      tick(EH);
      raw_v[2] = 1'b0;
      tick(20);
      check("eight_invalid_e", int'(e_seen > 0), 1);

      // randomized phase
      pulse_reset(2);
      for (int s = 0; s < 80; s++) begin
         raw_v = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 3))
               0:       valid_combo = 3'b000;
               1:       valid_combo = 3'b001;
               2:       valid_combo = 3'b011;
               default: valid_combo = 3'b111;
            endcase
            raw_v[2:0] = valid_combo;
         end
         seg_len = $urandom_range(1, 14);
         tick(seg_len);
         if ($urandom_range(0, 24) == 0) pulse_reset($urandom_range(1, 2));
      end

      tick(3);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
